// File: rtl/multiplicador_pkg.sv
// Shared constants and encodings for the sequential Booth multiplier and its
// HI/LO write interface.
package multiplicador_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned ITER  = WIDTH;
  localparam int unsigned CNT_W = $clog2(ITER) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'b00,
    BOOTH_ADD = 2'b01,
    BOOTH_SUB = 2'b10
  } booth_op_t;

  // One Booth iteration's working set: accumulator, multiplier, extra bit.
  typedef struct packed {
    logic [WIDTH:0]   a;
    logic [WIDTH-1:0] q;
    logic             q_1;
  } booth_t;

  // Radix-2 Booth recoding of {Q[0], Q_1}.
  function automatic booth_op_t booth_decode(input logic q0, input logic q_1);
    case ({q0, q_1})
      2'b01:   return BOOTH_ADD;
      2'b10:   return BOOTH_SUB;
      default: return BOOTH_NOP;
    endcase
  endfunction

endpackage

// File: rtl/multiplicador_if.sv
// Start/operand and HI/LO result bundle between control unit and multiplier.
interface multiplicador_if;
  import multiplicador_pkg::*;

  logic             MultCtrl;
  logic [WIDTH-1:0] multiplicando;
  logic [WIDTH-1:0] multiplicador;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             busy;
  logic             done;

  modport master (
    output MultCtrl, multiplicando, multiplicador,
    input  HI, LO, busy, done
  );

  modport slave (
    input  MultCtrl, multiplicando, multiplicador,
    output HI, LO, busy, done
  );
endinterface

// File: rtl/multiplicador_booth_step.sv
// One combinational radix-2 Booth iteration: conditional add/sub of M, then
// arithmetic right shift of {A,Q,Q_1}.
module multiplicador_booth_step
  import multiplicador_pkg::*;
(
  input  booth_t         cur,
  input  logic [WIDTH:0] m,
  output booth_t         nxt
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = cur.a;
    case (booth_decode(cur.q[0], cur.q_1))
      BOOTH_ADD: sum = cur.a + m;
      BOOTH_SUB: sum = cur.a - m;
      default:   sum = cur.a;
    endcase
  end

  // A's sign bit fills the vacated MSB; the 33-bit A keeps M = -2^31 exact.
  always_comb begin
    nxt.a   = {sum[WIDTH], sum[WIDTH:1]};
    nxt.q   = {sum[0], cur.q[WIDTH-1:1]};
    nxt.q_1 = cur.q[0];
  end

endmodule

// File: rtl/multiplicador.sv
// Sequential signed WIDTH x WIDTH Booth multiplier writing the 2*WIDTH product
// into HI/LO; one iteration per clock, done pulses when HI/LO update.
module multiplicador
  import multiplicador_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  multiplicador_if.slave bus
);

  state_t           state, state_d;
  logic [WIDTH:0]   m, m_d;
  booth_t           acc, acc_d, step;
  logic [CNT_W-1:0] count, count_d;
  logic [WIDTH-1:0] hi, hi_d, lo, lo_d;
  logic             busy, busy_d, done, done_d;

  multiplicador_booth_step u_step (
    .cur (acc),
    .m   (m),
    .nxt (step)
  );

  // State and registered datapath/outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      m     <= '0;
      acc   <= '0;
      count <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      m     <= m_d;
      acc   <= acc_d;
      count <= count_d;
      hi    <= hi_d;
      lo    <= lo_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

  // Next-state logic; the unused encoding falls back to IDLE.
  always_comb begin
    state_d = IDLE;
    case (state)
      IDLE:    state_d = bus.MultCtrl ? RUN : IDLE;
      RUN:     state_d = (count == CNT_W'(ITER - 1)) ? FIN : RUN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    m_d     = m;
    acc_d   = acc;
    count_d = count;
    hi_d    = hi;
    lo_d    = lo;
    busy_d  = busy;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.MultCtrl) begin
          m_d     = {bus.multiplicando[WIDTH-1], bus.multiplicando};
          acc_d   = '{a: '0, q: bus.multiplicador, q_1: 1'b0};
          count_d = '0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        acc_d   = step;
        count_d = count + CNT_W'(1);
      end
      FIN: begin
        hi_d   = acc.a[WIDTH-1:0];
        lo_d   = acc.q;
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign bus.HI   = hi;
  assign bus.LO   = lo;
  assign bus.busy = busy;
  assign bus.done = done;

endmodule

// File: tb/tb_multiplicador.sv
// Directed self-checking bench for the Booth multiplier: products, latency,
// busy/done timing, operand hold-off, back-to-back start and mid-run reset.
module tb_multiplicador;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  multiplicador_if bus ();

  multiplicador u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present operands with MultCtrl high across one edge (the start edge).
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    bus.MultCtrl      = 1'b1;
    bus.multiplicando = a;
    bus.multiplicador = b;
    @(posedge clk); #1;
    bus.MultCtrl = 1'b0;
  endtask

  // Wait (bounded) for done; counts edges after start, busy samples and any
  // HI/LO change seen before done.
  task automatic await_done(input bit hold, output int lat, output int busy_n,
                            output int partial);
    logic [63:0] prev;
    prev    = {bus.HI, bus.LO};
    lat     = 0;
    partial = 0;
    busy_n  = bus.busy ? 1 : 0;
    if (hold) bus.MultCtrl = 1'b1;
    while (!bus.done && lat < 40) begin
      if (hold) begin
        bus.multiplicando = $urandom;
        bus.multiplicador = $urandom;
      end
      @(posedge clk); #1;
      lat++;
      if (!bus.done) begin
        if (bus.busy) busy_n++;
        if ({bus.HI, bus.LO} !== prev) partial++;
      end
    end
    if (hold) bus.MultCtrl = 1'b0;
  endtask

  task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input bit hold);
    int lat, busy_n, partial;
    launch(a, b);
    await_done(hold, lat, busy_n, partial);
    check({tag, "_lat"}, 64'(lat), 64'd33);
    check({tag, "_prod"}, {bus.HI, bus.LO}, exp);
    check({tag, "_nopartial"}, 64'(partial), 64'd0);
    if (tag == "6x7") check({tag, "_busy_cycles"}, 64'(busy_n), 64'd33);
    @(posedge clk); #1;
    check({tag, "_done_drop"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int lat, busy_n, partial, seen;
    rst_n             = 1'b0;
    bus.MultCtrl      = 1'b0;
    bus.multiplicando = '0;
    bus.multiplicador = '0;
    #12;
    check("rst_hilo", {bus.HI, bus.LO}, 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_mult("6x7",       32'd6,         32'd7,         64'h00000000_0000002A, 1'b0);
    run_mult("m3x5",      32'hFFFFFFFD,  32'h00000005,  64'hFFFFFFFF_FFFFFFF1, 1'b0);
    run_mult("min_min",   32'h80000000,  32'h80000000,  64'h40000000_00000000, 1'b0);
    run_mult("min_m1",    32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000, 1'b0);
    run_mult("max_max",   32'h7FFFFFFF,  32'h7FFFFFFF,  64'h3FFFFFFF_00000001, 1'b0);
    run_mult("hold",      32'h00001234,  32'hFFFFFFFE,  64'hFFFFFFFF_FFFFDB98, 1'b1);
    check("hold_idle_busy", 64'(bus.busy), 64'd0);

    // Start a new operation in the very cycle done is high.
    launch(32'h00010000, 32'h00010000);
    await_done(1'b0, lat, busy_n, partial);
    check("b2b1_prod", {bus.HI, bus.LO}, 64'h00000001_00000000);
    launch(32'hFFFFFFFF, 32'hFFFFFFFF);
    check("b2b2_busy", 64'(bus.busy), 64'd1);
    check("b2b2_done", 64'(bus.done), 64'd0);
    await_done(1'b0, lat, busy_n, partial);
    check("b2b2_lat", 64'(lat), 64'd33);
    check("b2b2_prod", {bus.HI, bus.LO}, 64'h00000000_00000001);

    // Reset at iteration 10 aborts and clears HI/LO with no done pulse.
    @(posedge clk); #1;
    launch(32'h00000100, 32'h00000100);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check("mrst_hilo", {bus.HI, bus.LO}, 64'd0);
    check("mrst_busy", 64'(bus.busy), 64'd0);
    check("mrst_done", 64'(bus.done), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) seen++;
    end
    check("mrst_no_done", 64'(seen), 64'd0);
    check("mrst_hilo_after", {bus.HI, bus.LO}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
